// File: rtl/cache_mem_arbiter_if.sv
// Bundles the icache client, dcache client and cacheline-adapter signals of the arbiter.
// Latency: none (wires only).
// Backpressure: none; each client holds its request until its resp pulse.
//   slave  : arbiter view (client requests and adapter response in; grant-side signals out)
//   master : environment view (caches and adapter), the mirror of slave
interface cache_mem_arbiter_if;
    // icache client
    logic         i_read;
    logic [31:0]  i_addr;
    logic [255:0] i_rdata;
    logic         i_resp;
    // dcache client
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    // cacheline adapter
    logic         ca_read;
    logic         ca_write;
    logic [31:0]  ca_addr;
    logic [255:0] ca_wdata;
    logic [255:0] ca_rdata;
    logic         ca_resp;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, ca_rdata, ca_resp,
        output i_rdata, i_resp, d_rdata, d_resp, ca_read, ca_write, ca_addr, ca_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, ca_rdata, ca_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, ca_read, ca_write, ca_addr, ca_wdata
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one cacheline adapter between icache and dcache, one transaction at a time.
// Latency: request sampled in idle drives the adapter one cycle later; resp is combinational.
// Backpressure: a losing client simply holds its request; an in-flight transfer cannot be aborted.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : client and adapter signals (slave modport)
module cache_mem_arbiter #(
    parameter int unsigned s_offset  = 5,
    parameter bit          prio_mode = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_mem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ICACHE = 2'd1,
        S_DCACHE = 2'd2
    } state_t;

    localparam logic [31:0] ADDR_MASK = ~((32'd1 << s_offset) - 32'd1);

    state_t       state_q;
    logic         last_grant_q;   // 1 = dcache got the most recent grant
    logic         ca_read_q;
    logic         ca_write_q;
    logic [31:0]  ca_addr_q;
    logic [255:0] ca_wdata_q;

    logic i_req;
    logic d_req;
    logic pick_d;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    // dcache wins when alone, under fixed priority, or when icache had the last grant.
    assign pick_d = d_req & (~i_req | prio_mode | ~last_grant_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            ca_read_q    <= 1'b0;
            ca_write_q   <= 1'b0;
            ca_addr_q    <= 32'd0;
            ca_wdata_q   <= 256'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_d) begin
                        state_q      <= S_DCACHE;
                        last_grant_q <= 1'b1;
                        // read+write together is treated as a write-back
                        ca_read_q    <= ~bus.d_write;
                        ca_write_q   <= bus.d_write;
                        ca_addr_q    <= bus.d_addr & ADDR_MASK;
                        ca_wdata_q   <= bus.d_wdata;
                    end else if (i_req) begin
                        state_q      <= S_ICACHE;
                        last_grant_q <= 1'b0;
                        ca_read_q    <= 1'b1;
                        ca_write_q   <= 1'b0;
                        ca_addr_q    <= bus.i_addr & ADDR_MASK;
                    end
                end
                S_ICACHE, S_DCACHE: begin
                    // strobes stay up through the resp cycle, then drop in the forced idle cycle
                    if (bus.ca_resp) begin
                        state_q    <= S_IDLE;
                        ca_read_q  <= 1'b0;
                        ca_write_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ca_read  = ca_read_q;
    assign bus.ca_write = ca_write_q;
    assign bus.ca_addr  = ca_addr_q;
    assign bus.ca_wdata = ca_wdata_q;

    assign bus.i_rdata = bus.ca_rdata;
    assign bus.d_rdata = bus.ca_rdata;
    assign bus.i_resp  = (state_q == S_ICACHE) & bus.ca_resp;
    assign bus.d_resp  = (state_q == S_DCACHE) & bus.ca_resp;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a per-cycle vector table on a round-robin instance,
// then hand sequences for async reset, post-reset tie and a fixed-priority instance.
// All expected values are written out by hand in the table and sequences.
module tb_cache_mem_arbiter;

    logic clk;
    logic rst;

    cache_mem_arbiter_if bus0 ();
    cache_mem_arbiter_if bus1 ();

    cache_mem_arbiter #(.s_offset(5), .prio_mode(1'b0)) dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    cache_mem_arbiter #(.s_offset(5), .prio_mode(1'b1)) dut_fp (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         i_read;
        logic [31:0]  i_addr;
        logic         d_read;
        logic         d_write;
        logic [31:0]  d_addr;
        logic [255:0] d_wdata;
        logic         ca_resp;
        logic         e_rd;
        logic         e_wr;
        logic [31:0]  e_addr;
        logic [255:0] e_wdata;
        logic         e_iresp;
        logic         e_dresp;
    } vec_t;

    int total;
    int bad;

    localparam logic [255:0] W1   = {{7{32'h0}}, 32'h00111100};
    localparam logic [255:0] ALT  = {8{32'hCAFEF00D}};
    localparam logic [255:0] W2   = {8{32'hABCD0123}};
    localparam logic [255:0] W3   = {8{32'h5A5A0F0F}};
    localparam logic [255:0] LINE = {8{32'h11111111}};

    function automatic vec_t mk(input logic ir, input logic [31:0] ia,
                                input logic dr, input logic dw, input logic [31:0] da,
                                input logic [255:0] dwd, input logic rsp,
                                input logic erd, input logic ewr, input logic [31:0] ea,
                                input logic [255:0] ewd, input logic eir, input logic edr);
        vec_t v;
        v.i_read = ir;  v.i_addr = ia;
        v.d_read = dr;  v.d_write = dw; v.d_addr = da; v.d_wdata = dwd;
        v.ca_resp = rsp;
        v.e_rd = erd;   v.e_wr = ewr;   v.e_addr = ea; v.e_wdata = ewd;
        v.e_iresp = eir; v.e_dresp = edr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        logic [255:0] rdat;
        logic [31:0]  kk;

        total = 0;
        bad   = 0;

        //           ir  i_addr        dr dw d_addr        d_wdata rsp | rd wr ca_addr       ca_wdata ir dr
        // icache-only read, client drops request before resp
        tbl.push_back(mk(1, 32'h0011008C, 0, 0, 32'h0,        '0,  0,   0, 0, 32'h0,        '0,  0, 0)); // r0
        tbl.push_back(mk(1, 32'h0011008C, 0, 0, 32'h0,        '0,  0,   1, 0, 32'h00110080, '0,  0, 0)); // r1
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,        '0,  1,   1, 0, 32'h00110080, '0,  1, 0)); // r2
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,        '0,  0,   0, 0, 32'h00110080, '0,  0, 0)); // r3
        // dcache write-back, inputs change while busy
        tbl.push_back(mk(0, 32'h0,        0, 1, 32'hE0000000, W1,  0,   0, 0, 32'h00110080, '0,  0, 0)); // r4
        tbl.push_back(mk(0, 32'h0,        0, 1, 32'h12345678, ALT, 0,   0, 1, 32'hE0000000, W1,  0, 0)); // r5
        tbl.push_back(mk(0, 32'h0,        0, 1, 32'h12345678, ALT, 1,   0, 1, 32'hE0000000, W1,  0, 1)); // r6
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,        '0,  0,   0, 0, 32'hE0000000, W1,  0, 0)); // r7
        // tie: icache first (dcache had last grant), then dcache after one idle cycle
        tbl.push_back(mk(1, 32'h00000040, 1, 0, 32'h00000FFF, W2,  0,   0, 0, 32'hE0000000, W1,  0, 0)); // r8
        tbl.push_back(mk(1, 32'h00000040, 1, 0, 32'h00000FFF, W2,  0,   1, 0, 32'h00000040, W1,  0, 0)); // r9
        tbl.push_back(mk(1, 32'h00000040, 1, 0, 32'h00000FFF, W2,  1,   1, 0, 32'h00000040, W1,  1, 0)); // r10
        tbl.push_back(mk(0, 32'h0,        1, 0, 32'h00000FFF, W2,  0,   0, 0, 32'h00000040, W1,  0, 0)); // r11
        tbl.push_back(mk(0, 32'h0,        1, 0, 32'h00000FFF, W2,  0,   1, 0, 32'h00000FE0, W2,  0, 0)); // r12
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,        '0,  1,   1, 0, 32'h00000FE0, W2,  0, 1)); // r13
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,        '0,  0,   0, 0, 32'h00000FE0, W2,  0, 0)); // r14
        // second tie alternates to icache; dcache read+write issues as a write
        tbl.push_back(mk(1, 32'h00002000, 1, 1, 32'h00003021, W3,  0,   0, 0, 32'h00000FE0, W2,  0, 0)); // r15
        tbl.push_back(mk(1, 32'h00002000, 1, 1, 32'h00003021, W3,  0,   1, 0, 32'h00002000, W2,  0, 0)); // r16
        tbl.push_back(mk(0, 32'h0,        1, 1, 32'h00003021, W3,  1,   1, 0, 32'h00002000, W2,  1, 0)); // r17
        tbl.push_back(mk(0, 32'h0,        1, 1, 32'h00003021, W3,  0,   0, 0, 32'h00002000, W2,  0, 0)); // r18
        tbl.push_back(mk(0, 32'h0,        1, 1, 32'h00003021, W3,  0,   0, 1, 32'h00003020, W3,  0, 0)); // r19
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,        '0,  1,   0, 1, 32'h00003020, W3,  0, 1)); // r20
        // stray resp in idle
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,        '0,  1,   0, 0, 32'h00003020, W3,  0, 0)); // r21
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,        '0,  0,   0, 0, 32'h00003020, W3,  0, 0)); // r22
        // dcache request queued behind an icache transfer
        tbl.push_back(mk(1, 32'h00004000, 0, 0, 32'h0,        '0,  0,   0, 0, 32'h00003020, W3,  0, 0)); // r23
        tbl.push_back(mk(1, 32'h00004000, 1, 0, 32'h00005000, '0,  0,   1, 0, 32'h00004000, W3,  0, 0)); // r24
        tbl.push_back(mk(0, 32'h0,        1, 0, 32'h00005000, '0,  0,   1, 0, 32'h00004000, W3,  0, 0)); // r25
        tbl.push_back(mk(0, 32'h0,        1, 0, 32'h00005000, '0,  1,   1, 0, 32'h00004000, W3,  1, 0)); // r26
        tbl.push_back(mk(0, 32'h0,        1, 0, 32'h00005000, '0,  0,   0, 0, 32'h00004000, W3,  0, 0)); // r27
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,        '0,  0,   1, 0, 32'h00005000, '0,  0, 0)); // r28
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,        '0,  1,   1, 0, 32'h00005000, '0,  0, 1)); // r29
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,        '0,  0,   0, 0, 32'h00005000, '0,  0, 0)); // r30

        // quiet inputs, reset asserted from time zero
        rst = 1'b0;
        bus0.i_read = 0; bus0.i_addr = '0; bus0.d_read = 0; bus0.d_write = 0;
        bus0.d_addr = '0; bus0.d_wdata = '0; bus0.ca_rdata = '0; bus0.ca_resp = 0;
        bus1.i_read = 0; bus1.i_addr = '0; bus1.d_read = 0; bus1.d_write = 0;
        bus1.d_addr = '0; bus1.d_wdata = '0; bus1.ca_rdata = '0; bus1.ca_resp = 0;

        #12;
        chk("reset.ca_read",  bus0.ca_read,  0);
        chk("reset.ca_write", bus0.ca_write, 0);
        chk("reset.ca_addr",  bus0.ca_addr,  0);
        chk("reset.ca_wdata", bus0.ca_wdata, 0);
        chk("reset.i_resp",   bus0.i_resp,   0);
        chk("reset.d_resp",   bus0.d_resp,   0);
        @(posedge clk);
        #3 rst = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            cyc();
            kk   = k;
            rdat = (k == 2) ? LINE : {8{kk ^ 32'hA5A50000}};
            bus0.i_read   = tbl[k].i_read;
            bus0.i_addr   = tbl[k].i_addr;
            bus0.d_read   = tbl[k].d_read;
            bus0.d_write  = tbl[k].d_write;
            bus0.d_addr   = tbl[k].d_addr;
            bus0.d_wdata  = tbl[k].d_wdata;
            bus0.ca_resp  = tbl[k].ca_resp;
            bus0.ca_rdata = rdat;
            #1;
            chk($sformatf("r%0d.ca_read", k),  bus0.ca_read,  tbl[k].e_rd);
            chk($sformatf("r%0d.ca_write", k), bus0.ca_write, tbl[k].e_wr);
            chk($sformatf("r%0d.ca_addr", k),  bus0.ca_addr,  tbl[k].e_addr);
            chk($sformatf("r%0d.ca_wdata", k), bus0.ca_wdata, tbl[k].e_wdata);
            chk($sformatf("r%0d.i_resp", k),   bus0.i_resp,   tbl[k].e_iresp);
            chk($sformatf("r%0d.d_resp", k),   bus0.d_resp,   tbl[k].e_dresp);
            chk($sformatf("r%0d.i_rdata", k),  bus0.i_rdata,  rdat);
            chk($sformatf("r%0d.d_rdata", k),  bus0.d_rdata,  rdat);
        end

        // async reset in the middle of an icache read
        bus0.i_read = 1; bus0.i_addr = 32'h77777777;
        cyc();
        bus0.i_read = 0;
        #1;
        chk("arst.pre_ca_read", bus0.ca_read, 1);
        chk("arst.pre_ca_addr", bus0.ca_addr, 32'h77777760);
        #1 rst = 1'b0;
        bus0.ca_resp = 1;
        #1;
        chk("arst.ca_read", bus0.ca_read, 0);
        chk("arst.ca_addr", bus0.ca_addr, 0);
        chk("arst.i_resp",  bus0.i_resp,  0);
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("arst.stray_i_resp", bus0.i_resp, 0);
        chk("arst.stray_d_resp", bus0.d_resp, 0);
        cyc();
        chk("arst.stray2_i_resp", bus0.i_resp, 0);
        chk("arst.stray2_d_resp", bus0.d_resp, 0);
        chk("arst.stray2_ca_read", bus0.ca_read, 0);
        bus0.ca_resp = 0;

        // first tie after reset goes to icache, dcache follows after one idle cycle
        bus0.i_read = 1; bus0.i_addr = 32'h00000100;
        bus0.d_read = 1; bus0.d_addr = 32'h00000200;
        cyc();
        chk("tie0.ca_read", bus0.ca_read, 1);
        chk("tie0.ca_addr", bus0.ca_addr, 32'h00000100);
        bus0.ca_resp = 1; bus0.i_read = 0;
        #1;
        chk("tie0.i_resp", bus0.i_resp, 1);
        chk("tie0.d_resp", bus0.d_resp, 0);
        cyc();
        bus0.ca_resp = 0;
        #1;
        chk("tie0.idle_ca_read", bus0.ca_read, 0);
        cyc();
        chk("tie1.ca_read", bus0.ca_read, 1);
        chk("tie1.ca_addr", bus0.ca_addr, 32'h00000200);
        bus0.ca_resp = 1; bus0.d_read = 0;
        #1;
        chk("tie1.d_resp", bus0.d_resp, 1);
        cyc();
        bus0.ca_resp = 0;

        // fixed priority: dcache wins every tie, icache only once dcache goes quiet
        bus1.i_read = 1; bus1.i_addr = 32'h00000080;
        bus1.d_read = 1; bus1.d_addr = 32'h0000003F;
        cyc();
        chk("fp0.ca_read", bus1.ca_read, 1);
        chk("fp0.ca_addr", bus1.ca_addr, 32'h00000020);
        bus1.ca_resp = 1;
        #1;
        chk("fp0.d_resp", bus1.d_resp, 1);
        chk("fp0.i_resp", bus1.i_resp, 0);
        cyc();
        bus1.ca_resp = 0;
        #1;
        chk("fp0.idle_ca_read", bus1.ca_read, 0);
        cyc();
        chk("fp1.ca_read", bus1.ca_read, 1);
        chk("fp1.ca_addr", bus1.ca_addr, 32'h00000020);
        bus1.ca_resp = 1; bus1.d_read = 0;
        #1;
        chk("fp1.d_resp", bus1.d_resp, 1);
        cyc();
        bus1.ca_resp = 0;
        cyc();
        chk("fp2.ca_read", bus1.ca_read, 1);
        chk("fp2.ca_addr", bus1.ca_addr, 32'h00000080);
        bus1.ca_resp = 1; bus1.i_read = 0;
        #1;
        chk("fp2.i_resp", bus1.i_resp, 1);
        chk("fp2.d_resp", bus1.d_resp, 0);
        cyc();
        bus1.ca_resp = 0;
        #1;
        chk("fp2.idle_ca_read", bus1.ca_read, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the single cacheline adapter (physical-memory side, 256-bit lines) between the instruction cache and the data cache. Each cache connects to its client port as if it owned the adapter; the arbiter grants one client per transaction, registers the request toward the adapter, and routes the adapter response back to the granted client only. It sits between the two `cache` instances and the `cacheline_adapter` in the memory hierarchy.

## Interface
- `s_offset`, 5, line offset bits; the low `s_offset` bits of the granted address are forced to 0 on `ca_addr`
- `prio_mode`, 0, 0 = round-robin on simultaneous requests; 1 = fixed priority, dcache wins
- `clk`  in  1  clock, all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `i_read`  in  1  icache line read request
- `i_addr`  in  32  icache line address
- `i_rdata`  out  256  line returned to icache
- `i_resp`  out  1  icache transaction done
- `d_read`  in  1  dcache line read request
- `d_write`  in  1  dcache line write-back request
- `d_addr`  in  32  dcache line address
- `d_wdata`  in  256  dcache write-back line
- `d_rdata`  out  256  line returned to dcache
- `d_resp`  out  1  dcache transaction done
- `ca_read`  out  1  adapter read (`read_i`)
- `ca_write`  out  1  adapter write (`write_i`)
- `ca_addr`  out  32  adapter address (`address_i`)
- `ca_wdata`  out  256  adapter write line (`line_i`)
- `ca_rdata`  in  256  adapter read line (`line_o`)
- `ca_resp`  in  1  adapter done (`resp_o`)

## Operation
- **States:**
  - `s_idle`: no grant.
  - `s_icache`: icache transaction in flight.
  - `s_dcache`: dcache transaction in flight.
- **`s_idle` transitions:**
  - Only `i_read` asserted: go to `s_icache`.
  - Only `d_read` or `d_write` asserted: go to `s_dcache`.
  - No request: stay.
- **Both clients requesting in `s_idle`:**
  - `prio_mode=1`: dcache is granted.
  - `prio_mode=0`: grant the client not recorded in `last_grant`.
  - `last_grant` is updated on every grant.
- **On grant, capture into output registers:**
  - `ca_addr` = client address with the low `s_offset` bits zeroed.
  - `ca_wdata` = `d_wdata` for a dcache grant, unchanged for an icache grant.
  - Operation type: icache is read-only. If `d_read` and `d_write` are both high, the transaction is a write.
- **Register stability:** `ca_*` outputs come from these registers and do not follow client inputs while busy.
- **Busy states:** on `ca_resp=1`, go to `s_idle`. Otherwise stay, even if the client drops its request; an in-flight adapter transaction cannot be aborted.
- **Read data routing:**
  - `i_rdata` and `d_rdata` are wired to `ca_rdata` at all times.
  - `i_resp = (state==s_icache) & ca_resp`.
  - `d_resp = (state==s_dcache) & ca_resp`.
- **Stray response:** `ca_resp` in `s_idle` is ignored, and no client resp is raised.

## Timing
- **Reset values:**
  - `state=s_idle`, `last_grant=dcache`, so icache wins the first tie in round-robin mode.
  - `ca_read=0`, `ca_write=0`, `ca_addr=0`, `ca_wdata=0`, `i_resp=0`, `d_resp=0`.
  - Reset takes effect immediately, without a clock edge, including mid-transaction. No resp is delivered for an aborted transaction.
- **Request to adapter:** a request sampled in `s_idle` at edge N drives `ca_read`/`ca_write` high from cycle N+1. Latency is one cycle.
- **Strobe hold:** `ca_read`/`ca_write` stay high through the cycle in which `ca_resp=1`, and drop in the next cycle.
- **Response to client:** `x_resp` is combinational, in the same cycle as `ca_resp`. It pulses for exactly one cycle per transaction.
- **Turnaround:** at least one `s_idle` cycle separates transactions. Back-to-back grants therefore show `ca_read`/`ca_write` low for exactly one cycle.
- **Waiting client:** a request held during the other client's transaction is granted at the `s_idle` edge that follows that client's `ca_resp`.
- **Mutual exclusion:** `ca_read` and `ca_write` are never both high.

## Test plan
- **Icache-only read:**
  - Stimulus: `i_read=1`, `i_addr=0x0011008C`.
  - From the next cycle: `ca_read=1`, `ca_write=0`, `ca_addr=0x00110080`.
  - Feed `ca_rdata={8{32'h11111111}}` with `ca_resp=1` for one cycle.
  - Required: `i_resp=1` in that same cycle, `i_rdata` equals the fed line, `d_resp=0`, and `ca_read=0` in the following cycle.
- **Dcache write-back:**
  - Stimulus: `d_write=1`, `d_addr=0xE0000000`, `d_wdata={{7{32'h0}},32'h00111100}`.
  - Required: `ca_write=1`, `ca_read=0`, matching `ca_addr` and `ca_wdata`.
  - During the transaction, change `d_addr`/`d_wdata`; `ca_addr`/`ca_wdata` must stay constant until `ca_resp`.
- **Ties:**
  - `prio_mode=0`: `i_read` and `d_read` rise together after reset. Required grant order is icache, then dcache. A second simultaneous pair must also alternate.
  - `prio_mode=1`: dcache is always granted first.
- **Queued request:**
  - Stimulus: `d_read` asserts mid icache transaction.
  - Required: no dcache activity until the icache `ca_resp`, then exactly one idle cycle, then `ca_read` for dcache with `d_addr`.
- **Async reset mid-transaction:**
  - Stimulus: drive `rst=0` between clock edges while `ca_read=1`.
  - Required: `ca_read=0` before the next edge.
  - After `rst=1`, a stray `ca_resp=1` raises neither `i_resp` nor `d_resp`.
- **Illegal and abandoned requests:**
  - `d_read=d_write=1` is issued as a write.
  - A client that drops its request mid-transaction still receives exactly one resp pulse when `ca_resp` arrives.
